hazard_ctrl: RTL

- Pipeline sequencing controller for the 5-stage core.
- Drives the write-enable and flush controls of the PC and the IFID register, and the bubble control of the ID/EX register.
- Freezes the whole pipeline during multi-cycle data-memory accesses.
- Arbitrates between memory stall, load-use stall and branch flush, and keeps saturating performance counters.

---
 rtl/hazard_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline sequencing controller for the 5-stage core. It arbitrates between
//   a multi-cycle data-memory freeze, a load-use stall and a taken-branch
//   flush, and drives the PC / IFID enables and the ID/EX bubble.
//   It also keeps two saturating performance counters.
//
// Parameters
//   MEM_LAT  data-memory access latency in cycles (1..15)
//   CNT_W    width of the performance counters
//
// Ports
//   Clk             system clock, all state updates on the rising edge
//   Start           synchronous active-low reset
//   idex_memread_i  instruction in EX is a load
//   idex_rd_i       destination register of the instruction in EX
//   ifid_rs_i       rs field of the instruction in IFID
//   ifid_rt_i       rt field of the instruction in IFID
//   branch_taken_i  branch resolved taken in ID this cycle
//   dmem_req_i      instruction in MEM issues a data-memory access
//   pc_write_o      PC update enable
//   ifid_write_o    IFID register load enable
//   ifid_flush_o    IFID clears to NOP at the next edge
//   idex_bubble_o   ID/EX loads a NOP
//   stall_all_o     freezes ID/EX, EX/MEM and MEM/WB
//   state_o         0 = RUN, 1 = MEM_WAIT
//   stall_cnt_o     cycles with pc_write_o=0 while Start=1 (saturating)
//   flush_cnt_o     cycles with ifid_flush_o=1 while Start=1 (saturating)
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int MEM_LAT = 3,
  parameter int CNT_W   = 16
) (
  input  logic             Clk,
  input  logic             Start,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rd_i,
  input  logic [4:0]       ifid_rs_i,
  input  logic [4:0]       ifid_rt_i,
  input  logic             branch_taken_i,
  input  logic             dmem_req_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             stall_all_o,
  output logic             state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

  // A memory access freezes the pipeline for MEM_LAT-1 cycles: the request
  // cycle itself plus MEM_LAT-2 cycles in MEM_WAIT. With MEM_LAT=2 the request
  // cycle alone covers the latency, so MEM_WAIT is never entered.
  localparam bit             MEM_STALL_EN = (MEM_LAT > 1);
  localparam bit             USE_WAIT     = (MEM_LAT > 2);
  localparam logic [3:0]     WAIT_INIT    = 4'((MEM_LAT > 2) ? (MEM_LAT - 2) : 0);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_e           state_q, state_d;
  logic [3:0]       wcnt_q, wcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             load_use_hz;

  assign load_use_hz = idex_memread_i && (idex_rd_i != 5'd0) &&
                       ((idex_rd_i == ifid_rs_i) || (idex_rd_i == ifid_rt_i));

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    stall_all_o   = 1'b0;

    if (!Start) begin
      // Reset also aborts any wait in progress.
      state_d       = ST_RUN;
      wcnt_d        = 4'd0;
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (dmem_req_i && MEM_STALL_EN) begin
            stall_all_o  = 1'b1;
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            if (USE_WAIT) begin
              state_d = ST_MEM_WAIT;
              wcnt_d  = WAIT_INIT;
            end
          end else if (load_use_hz) begin
            // A taken branch is dropped here; it re-resolves next cycle.
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
          end else if (branch_taken_i) begin
            ifid_flush_o = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          stall_all_o  = 1'b1;
          pc_write_o   = 1'b0;
          ifid_write_o = 1'b0;
          // wcnt counts the MEM_WAIT cycles still to go including this one.
          if (wcnt_q <= 4'd1) begin
            state_d = ST_RUN;
            wcnt_d  = 4'd0;
          end else begin
            wcnt_d = wcnt_q - 4'd1;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!Start) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (!pc_write_o && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + 1'b1;
      if (ifid_flush_o && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    state_q     <= state_d;
    wcnt_q      <= wcnt_d;
    stall_cnt_q <= stall_cnt_d;
    flush_cnt_q <= flush_cnt_d;
  end

  assign state_o     = Start ? state_q : 1'b0;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule
